fft16_stage_sequencer: RTL

- Control block that schedules one shared radix-2 butterfly unit over a 16-point in-place sample RAM.
- Computes a decimation-in-frequency FFT: natural-order input, bit-reversed result in RAM.
- Generates per-butterfly read addresses, twiddle index, stage number and delayed write-back addresses.
- Owns the start/busy/done handshake toward the audio front end and spectrum display logic.

---
 rtl/fft_pkg.sv | 54 +++++
 rtl/fft_delay_line.sv | 30 +++
 rtl/fft16_stage_sequencer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared types and address helpers for the 16-point DIF FFT stage sequencer.
package fft_pkg;

  localparam int FFT_LOG2     = 4;
  localparam int FFT_N        = 1 << FFT_LOG2;
  localparam int BF_PER_STAGE = FFT_N / 2;
  localparam int STAGE_W      = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_DONE   = 3'd3,
    ST_UNLOAD = 3'd4
  } fsm_state_e;

  typedef struct packed {
    logic [FFT_LOG2-1:0] a;
    logic [FFT_LOG2-1:0] b;
    logic [FFT_LOG2-2:0] tw;
  } bf_addr_t;

  function automatic logic [FFT_LOG2-1:0] bitreverse(input logic [FFT_LOG2-1:0] x);
    logic [FFT_LOG2-1:0] r;
    r = '0;
    for (int i = 0; i < FFT_LOG2; i++) begin
      r[i] = x[FFT_LOG2-1-i];
    end
    return r;
  endfunction

  // Butterfly k of stage s: pairs sit 'span' apart inside groups of 2*span.
  function automatic bf_addr_t bf_addr(input logic [FFT_LOG2-2:0] k,
                                       input logic [STAGE_W-1:0]  s);
    bf_addr_t            res;
    logic [FFT_LOG2-1:0] k_ext;
    logic [FFT_LOG2-1:0] span;
    logic [FFT_LOG2-1:0] mask;
    logic [FFT_LOG2-1:0] hi;
    logic [FFT_LOG2-2:0] k_lo;
    int                  sh_hi;
    k_ext  = {1'b0, k};
    span   = FFT_LOG2'(BF_PER_STAGE) >> s;
    mask   = span - FFT_LOG2'(1);
    sh_hi  = FFT_LOG2 - 1 - int'(s);
    hi     = (k_ext >> sh_hi) << (sh_hi + 1);
    res.a  = hi | (k_ext & mask);
    res.b  = res.a + span;
    k_lo   = k & mask[FFT_LOG2-2:0];
    res.tw = k_lo << s;
    return res;
  endfunction

endpackage

// File: rtl/fft_delay_line.sv
// Fixed-depth shift register that aligns write-back strobes and addresses
// with the butterfly result; synchronous clear flushes in-flight entries.
module fft_delay_line #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 9
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_pipe [DEPTH];

  // Shift one slot per cycle; clear drops everything still in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
    end else if (i_clr) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/fft16_stage_sequencer.sv
// Schedules one shared radix-2 DIF butterfly over a 16-point in-place RAM.
// Define FFT_BITREV_UNLOAD_EN to add a bit-reversed unload phase before done.
module fft16_stage_sequencer
  import fft_pkg::*;
#(
  parameter int N_LOG2 = FFT_LOG2,
  parameter int RD_LAT = 1,
  parameter int BF_LAT = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              bf_issue,
  output logic [N_LOG2-1:0] rd_addr_a,
  output logic [N_LOG2-1:0] rd_addr_b,
  output logic [N_LOG2-2:0] tw_idx,
  output logic [1:0]        stage,
  output logic              wb_valid,
  output logic [N_LOG2-1:0] wr_addr_a,
  output logic [N_LOG2-1:0] wr_addr_b
`ifdef FFT_BITREV_UNLOAD_EN
  ,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [N_LOG2-1:0] out_bin,
  output logic [N_LOG2-1:0] un_rd_addr
`endif
);

  localparam int D   = RD_LAT + BF_LAT;
  localparam int DCW = $clog2(D + 1);
  localparam int KW  = N_LOG2 - 1;
  localparam int DLW = 1 + 2 * N_LOG2;
  localparam logic [KW-1:0]  K_LAST     = KW'((1 << KW) - 1);
  localparam logic [1:0]     STAGE_LAST = 2'(N_LOG2 - 1);
  localparam logic [DCW-1:0] DRAIN_INIT = DCW'(D - 1);

  fsm_state_e      r_state;
  fsm_state_e      w_state_nxt;
  logic [KW-1:0]   r_k;
  logic [KW-1:0]   w_k_nxt;
  logic [1:0]      r_stage;
  logic [1:0]      w_stage_nxt;
  logic [DCW-1:0]  r_dcnt;
  logic [DCW-1:0]  w_dcnt_nxt;
  logic            w_issue_nxt;
  logic            w_busy_nxt;
  bf_addr_t        w_addr;

  logic              r_bf_issue;
  logic [N_LOG2-1:0] r_rd_addr_a;
  logic [N_LOG2-1:0] r_rd_addr_b;
  logic [N_LOG2-2:0] r_tw_idx;
  logic              r_busy;
  logic              r_done;
  logic [DLW-1:0]    w_dl_in;
  logic [DLW-1:0]    w_dl_out;

`ifdef FFT_BITREV_UNLOAD_EN
  localparam int UWW = $clog2(RD_LAT + 2);
  localparam logic [UWW-1:0]    UW_INIT = UWW'(RD_LAT);
  localparam logic [N_LOG2-1:0] UB_LAST = N_LOG2'((1 << N_LOG2) - 1);

  logic [N_LOG2-1:0] r_ub;
  logic [N_LOG2-1:0] w_ub_nxt;
  logic [UWW-1:0]    r_uw;
  logic [UWW-1:0]    w_uw_nxt;
  logic              r_out_valid;
  logic [N_LOG2-1:0] r_out_bin;
  logic [N_LOG2-1:0] r_un_rd_addr;
  logic              w_unload_nxt;
`endif

  // Next-state logic: abort wins, otherwise walk stages, drain, finish.
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_stage_nxt = r_stage;
    w_dcnt_nxt  = r_dcnt;
`ifdef FFT_BITREV_UNLOAD_EN
    w_ub_nxt    = r_ub;
    w_uw_nxt    = r_uw;
`endif
    if (abort) begin
      w_state_nxt = ST_IDLE;
      w_k_nxt     = '0;
      w_stage_nxt = '0;
      w_dcnt_nxt  = '0;
`ifdef FFT_BITREV_UNLOAD_EN
      w_ub_nxt    = '0;
      w_uw_nxt    = '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_state_nxt = ST_ISSUE;
            w_k_nxt     = '0;
            w_stage_nxt = '0;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (r_k == K_LAST) begin
            w_state_nxt = ST_DRAIN;
            w_dcnt_nxt  = DRAIN_INIT;
          end else begin
            w_k_nxt = r_k + KW'(1);
          end
        end
        // Wait out the pipeline so the next stage never reads a pending write.
        ST_DRAIN: begin
          if (r_dcnt != '0) begin
            w_dcnt_nxt = r_dcnt - DCW'(1);
          end else if (r_stage != STAGE_LAST) begin
            w_state_nxt = ST_ISSUE;
            w_stage_nxt = r_stage + 2'd1;
            w_k_nxt     = '0;
          end else begin
`ifdef FFT_BITREV_UNLOAD_EN
            w_state_nxt = ST_UNLOAD;
            w_ub_nxt    = '0;
            w_uw_nxt    = UW_INIT;
`else
            w_state_nxt = ST_DONE;
`endif
          end
        end
        ST_DONE: begin
          w_state_nxt = ST_IDLE;
          w_stage_nxt = '0;
          w_k_nxt     = '0;
        end
`ifdef FFT_BITREV_UNLOAD_EN
        ST_UNLOAD: begin
          if (r_out_valid && out_ready) begin
            if (r_ub == UB_LAST) begin
              w_state_nxt = ST_DONE;
            end else begin
              w_ub_nxt = r_ub + N_LOG2'(1);
              w_uw_nxt = UW_INIT;
            end
          end else if (r_uw != '0) begin
            w_uw_nxt = r_uw - UWW'(1);
          end else begin
            w_uw_nxt = r_uw;
          end
        end
`endif
        default: begin
          w_state_nxt = ST_IDLE;
          w_k_nxt     = '0;
          w_stage_nxt = '0;
          w_dcnt_nxt  = '0;
        end
      endcase
    end
  end

  assign w_issue_nxt = (w_state_nxt == ST_ISSUE);
  assign w_addr      = bf_addr(w_k_nxt, w_stage_nxt);
`ifdef FFT_BITREV_UNLOAD_EN
  assign w_unload_nxt = (w_state_nxt == ST_UNLOAD);
  assign w_busy_nxt   = w_issue_nxt || (w_state_nxt == ST_DRAIN) || w_unload_nxt;
`else
  assign w_busy_nxt   = w_issue_nxt || (w_state_nxt == ST_DRAIN);
`endif

  // State, counters and every output are registered from the next-state values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_k         <= '0;
      r_stage     <= '0;
      r_dcnt      <= '0;
      r_bf_issue  <= 1'b0;
      r_rd_addr_a <= '0;
      r_rd_addr_b <= '0;
      r_tw_idx    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef FFT_BITREV_UNLOAD_EN
      r_ub         <= '0;
      r_uw         <= '0;
      r_out_valid  <= 1'b0;
      r_out_bin    <= '0;
      r_un_rd_addr <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_k         <= w_k_nxt;
      r_stage     <= w_stage_nxt;
      r_dcnt      <= w_dcnt_nxt;
      r_bf_issue  <= w_issue_nxt;
      r_rd_addr_a <= w_issue_nxt ? w_addr.a : '0;
      r_rd_addr_b <= w_issue_nxt ? w_addr.b : '0;
      r_tw_idx    <= w_issue_nxt ? w_addr.tw : '0;
      r_busy      <= w_busy_nxt;
      r_done      <= (w_state_nxt == ST_DONE);
`ifdef FFT_BITREV_UNLOAD_EN
      r_ub         <= w_ub_nxt;
      r_uw         <= w_uw_nxt;
      r_out_valid  <= w_unload_nxt && (w_uw_nxt == '0);
      r_out_bin    <= w_unload_nxt ? w_ub_nxt : '0;
      r_un_rd_addr <= w_unload_nxt ? bitreverse(w_ub_nxt) : '0;
`endif
    end
  end

  assign w_dl_in = {r_bf_issue, r_rd_addr_a, r_rd_addr_b};

  fft_delay_line #(
    .DEPTH(D),
    .WIDTH(DLW)
  ) u_wb_delay (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_clr   (abort),
    .i_d     (w_dl_in),
    .o_q     (w_dl_out)
  );

  assign {wb_valid, wr_addr_a, wr_addr_b} = w_dl_out;

  assign busy      = r_busy;
  assign done      = r_done;
  assign bf_issue  = r_bf_issue;
  assign rd_addr_a = r_rd_addr_a;
  assign rd_addr_b = r_rd_addr_b;
  assign tw_idx    = r_tw_idx;
  assign stage     = r_stage;
`ifdef FFT_BITREV_UNLOAD_EN
  assign out_valid  = r_out_valid;
  assign out_bin    = r_out_bin;
  assign un_rd_addr = r_un_rd_addr;
`endif

endmodule
